// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port, decode handshake.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface if_fetch_unit_if #(
    parameter int IM_AW = 16
);
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             IM_enable;
    logic             IM_write;
    logic [31:0]      IM_in;
    logic [IM_AW-1:0] IM_address;
    logic [31:0]      IM_out;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_inst;
    logic [31:0]      id_pc;

    modport master (
        input  redirect_valid, redirect_pc, IM_out, id_ready,
        output IM_enable, IM_write, IM_in, IM_address,
        output id_valid, id_inst, id_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, IM_out, id_ready,
        input  IM_enable, IM_write, IM_in, IM_address,
        input  id_valid, id_inst, id_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, IM access and a small fetch queue to decode.
// Optional IF_FETCH_PERF_EN adds fetch/stall performance counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4,
    parameter int          IM_AW    = 16
) (
    input  logic  clk,
    input  logic  rst,
    if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(FQ_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [31:0]   qpc_q   [FQ_DEPTH];
    logic [31:0]   qinst_q [FQ_DEPTH];

    logic valid;
    logic pop;
    logic fire;

    assign valid = (cnt_q != '0);
    assign pop   = valid & bus.id_ready;
    assign fire  = rst & ~bus.redirect_valid & ((cnt_q != FULL_C) | pop);

    assign bus.IM_enable  = fire;
    assign bus.IM_write   = 1'b0;
    assign bus.IM_in      = '0;
    assign bus.IM_address = pc_q[IM_AW+1:2];

    // Gate the head so reset/flush never exposes stale storage.
    assign bus.id_valid = valid;
    assign bus.id_inst  = valid ? qinst_q[rd_q] : '0;
    assign bus.id_pc    = valid ? qpc_q[rd_q]   : '0;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (!rst) begin
            pc_d  = RESET_PC;
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end else if (bus.redirect_valid) begin
            pc_d  = {bus.redirect_pc[31:2], 2'b00};
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + {{PW{1'b0}}, fire} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        cnt_q <= cnt_d;
        rd_q  <= rd_d;
        wr_q  <= wr_d;
    end

    // Queue storage needs no reset; visibility is governed by cnt_q.
    always_ff @(posedge clk) begin
        if (fire) begin
            qpc_q[wr_q]   <= pc_q;
            qinst_q[wr_q] <= bus.IM_out;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!bus.redirect_valid && !fire) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed plan steps plus random traffic
// compared against a queue-level reference model of the fetch stage.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    if_fetch_unit_if #(.IM_AW(16)) bus ();

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4),
        .IM_AW    (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [15:0] a);
        case (a)
            16'd0:   return 32'h0000_0013;
            16'd1:   return 32'h0010_0093;
            16'd2:   return 32'h0020_0113;
            16'd3:   return 32'h0030_0193;
            default: return {a, ~a} ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign bus.IM_out = im_word(bus.IM_address);

    int checks   = 0;
    int failures = 0;

    logic [63:0] mq [$];
    logic [31:0] mpc;
    logic        known = 1'b0;
    logic        m_r, m_rv, m_pop, m_fire;
    logic [31:0] m_rp;
    logic [31:0] mf, ms;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle and compare everything visible in that cycle.
    task automatic drive(input logic r, input logic rv,
                         input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.id_ready       = rdy;
        #1;
        m_r    = r;
        m_rv   = rv;
        m_rp   = rp;
        m_pop  = known && (mq.size() != 0) && rdy;
        m_fire = r && !rv && known && ((mq.size() < 4) || m_pop);
        chk("IM_write", 64'(bus.IM_write), 64'd0);
        chk("IM_in", 64'(bus.IM_in), 64'd0);
        if (!r) chk("IM_enable_rst", 64'(bus.IM_enable), 64'd0);
        if (known) begin
            chk("IM_enable", 64'(bus.IM_enable), 64'(m_fire));
            chk("IM_address", 64'(bus.IM_address), 64'(mpc[17:2]));
            chk("id_valid", 64'(bus.id_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("id_pc", 64'(bus.id_pc), 64'(mq[0][63:32]));
                chk("id_inst", 64'(bus.id_inst), 64'(mq[0][31:0]));
            end else begin
                chk("id_pc_idle", 64'(bus.id_pc), 64'd0);
                chk("id_inst_idle", 64'(bus.id_inst), 64'd0);
            end
`ifdef IF_FETCH_PERF_EN
            chk("perf_fetch", 64'(perf_fetch_cnt), 64'(mf));
            chk("perf_stall", 64'(perf_stall_cnt), 64'(ms));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!m_r) begin
            mq.delete();
            mpc   = 32'h0;
            mf    = 32'h0;
            ms    = 32'h0;
            known = 1'b1;
        end else if (m_rv) begin
            mq.delete();
            mpc = {m_rp[31:2], 2'b00};
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_fire) begin
                mq.push_back({mpc, im_word(mpc[17:2])});
                mpc = mpc + 32'd4;
                mf  = mf + 32'd1;
            end else begin
                ms = ms + 32'd1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic rv,
                       input logic [31:0] rp, input logic rdy);
        drive(r, rv, rp, rdy);
        tick();
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;

        // Plan 1: reset two cycles, stream with id_ready high.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1);
            chk("t1_addr", 64'(bus.IM_address), 64'(i));
            tick();
        end
        drive(1, 0, 0, 1);
        chk("t1_pc_last", 64'(bus.id_pc), 64'h0000_000C);
        chk("t1_inst_last", 64'(bus.id_inst), 64'h0030_0193);
        tick();

        // Plan 2: stall from release, fill, then drain.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("t2_full_en", 64'(bus.IM_enable), 64'd0);
        chk("t2_full_addr", 64'(bus.IM_address), 64'h4);
        tick();
        drive(1, 0, 0, 1);
        chk("t2_pop_fire", 64'(bus.IM_enable), 64'd1);
        chk("t2_head", 64'(bus.id_pc), 64'h0);
        tick();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);

        // Plan 3: redirect while full with misaligned target.
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
        drive(1, 1, 32'h0000_0103, 0);
        chk("t3_redir_en", 64'(bus.IM_enable), 64'd0);
        tick();
        drive(1, 0, 0, 0);
        chk("t3_valid0", 64'(bus.id_valid), 64'd0);
        chk("t3_addr", 64'(bus.IM_address), 64'h40);
        tick();
        drive(1, 0, 0, 1);
        chk("t3_pc", 64'(bus.id_pc), 64'h100);
        tick();

        // Plan 4: PC wrap at the top of the address space.
        cyc(1, 1, 32'hFFFF_FFFC, 1);
        drive(1, 0, 0, 1);
        chk("t4_addr_top", 64'(bus.IM_address), 64'hFFFF);
        tick();
        drive(1, 0, 0, 1);
        chk("t4_addr_wrap", 64'(bus.IM_address), 64'h0);
        chk("t4_pc_top", 64'(bus.id_pc), 64'hFFFF_FFFC);
        tick();
        drive(1, 0, 0, 1);
        chk("t4_pc_wrap", 64'(bus.id_pc), 64'h0);
        tick();

        // Plan 5: mid-run reset with 3 queued, then redirect+pop.
        cyc(1, 1, 32'h0000_0200, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        chk("t5_rst_en", 64'(bus.IM_enable), 64'd0);
        tick();
        drive(1, 0, 0, 1);
        chk("t5_valid0", 64'(bus.id_valid), 64'd0);
        chk("t5_restart", 64'(bus.IM_address), 64'h0);
        tick();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        drive(1, 1, 32'h0000_0300, 1);
        chk("t5_pop_valid", 64'(bus.id_valid), 64'd1);
        tick();
        drive(1, 0, 0, 1);
        chk("t5_flush", 64'(bus.id_valid), 64'd0);
        tick();
        cyc(1, 1, 32'h0000_0400, 1);
        cyc(1, 1, 32'h0000_0500, 1);
        drive(1, 0, 0, 1);
        chk("t5_b2b_addr", 64'(bus.IM_address), 64'h140);
        tick();

`ifdef IF_FETCH_PERF_EN
        // Plan 6: counters over a stalled window, then reset.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("t6_fetch", 64'(perf_fetch_cnt), 64'd4);
        chk("t6_stall", 64'(perf_stall_cnt), 64'd6);
        tick();
        cyc(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("t6_fetch0", 64'(perf_fetch_cnt), 64'd0);
        chk("t6_stall0", 64'(perf_stall_cnt), 64'd0);
        tick();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic r, rv, rdy;
            logic [31:0] rp;
            r   = ($urandom_range(0, 49) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rp  = $urandom();
            cyc(r, rv, rp, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
